// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Holds the align FSM states and the RVC opcode mask.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [1:0] RVC_OPMASK = 2'b11;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_STRADDLE
  } fetch_state_e;

  function automatic logic rvc_half(input logic [15:0] h);
    return h[1:0] != RVC_OPMASK;
  endfunction

endpackage

// File: rtl/riscv_fetch_rvc_det.sv
// Compressed-instruction detect and sequential PC select.
// pc_next is pc+2 for RVC, pc+4 otherwise.
module riscv_fetch_rvc_det
  import riscv_pkg::*;
(
  input  logic [15:0]     half,
  input  logic [XLEN-1:0] pc,
  output logic            rvc,
  output logic [XLEN-1:0] pc_next
);

  assign rvc     = half[1:0] != RVC_OPMASK;
  assign pc_next = pc + (rvc ? 64'd2 : 64'd4);

endmodule

// File: rtl/riscv_fetch_align.sv
// Fetch stage: word reads from imem, realigned into RVC
// and 32-bit instructions presented to decode.
module riscv_fetch_align
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_riscv_fetch_clk,
  input  logic            i_riscv_fetch_rst,
  input  logic            i_riscv_fetch_stall,
  input  logic            i_riscv_fetch_redirect,
  input  logic [XLEN-1:0] i_riscv_fetch_redirect_pc,
  output logic            o_riscv_fetch_imem_req,
  output logic [XLEN-1:0] o_riscv_fetch_imem_addr,
  input  logic            i_riscv_fetch_imem_rvalid,
  input  logic [31:0]     i_riscv_fetch_imem_rdata,
  output logic [XLEN-1:0] o_riscv_fetch_pc_f,
  output logic [31:0]     o_riscv_fetch_inst_f,
  output logic [XLEN-1:0] o_riscv_fetch_pcplus4_f,
  output logic            o_riscv_fetch_valid_f
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [15:0]     buf_half, buf_half_n;
  logic [XLEN-1:0] buf_pc, buf_pc_n;
  logic            buf_vld, buf_vld_n;
  logic            drop, drop_n;
  logic            skid_vld, skid_vld_n;
  logic [31:0]     skid_data, skid_data_n;
  logic            valid_q, valid_n;
  logic [31:0]     inst_q, inst_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] pc4_q, pc4_n;

  logic            req_c;
  logic [XLEN-1:0] addr_c;
  logic [XLEN-1:0] word_a, word_a4, hi_pc;
  logic            wv;
  logic [31:0]     wd;
  logic [15:0]     lo, hi;
  logic            hi_rvc;
  logic [15:0]     pres_half;
  logic [XLEN-1:0] pres_pc;
  logic            det_rvc;
  logic [XLEN-1:0] det_next;
  logic            outstanding;
  logic            present;
  logic            take_hi;
  logic [31:0]     pres_inst;

  assign word_a  = fetch_pc & ~64'd3;
  assign word_a4 = word_a + 64'd4;
  assign hi_pc   = word_a | 64'd2;

  // Skid data wins: it is older than anything on the bus.
  assign wv     = skid_vld | i_riscv_fetch_imem_rvalid;
  assign wd     = skid_vld ? skid_data : i_riscv_fetch_imem_rdata;
  assign lo     = wd[15:0];
  assign hi     = wd[31:16];
  assign hi_rvc = rvc_half(hi);

  assign pres_half = (state == S_WAIT) ?
                     (fetch_pc[1] ? hi : lo) : buf_half;
  assign pres_pc   = (state == S_WAIT) ? fetch_pc : buf_pc;

  riscv_fetch_rvc_det u_det (
    .half    (pres_half),
    .pc      (pres_pc),
    .rvc     (det_rvc),
    .pc_next (det_next)
  );

  assign pres_inst = det_rvc ? {16'h0, pres_half} :
                     (state == S_STRADDLE) ? {lo, buf_half} : wd;

  assign outstanding = (state == S_WAIT || state == S_STRADDLE)
                     && !skid_vld && !i_riscv_fetch_imem_rvalid;

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    buf_half_n  = buf_half;
    buf_pc_n    = buf_pc;
    buf_vld_n   = buf_vld;
    drop_n      = drop;
    skid_vld_n  = skid_vld;
    skid_data_n = skid_data;
    valid_n     = valid_q;
    inst_n      = inst_q;
    pc_n        = pc_q;
    pc4_n       = pc4_q;
    req_c       = 1'b0;
    addr_c      = word_a;
    present     = 1'b0;
    take_hi     = 1'b0;

    if (i_riscv_fetch_redirect) begin
      state_n    = outstanding ? S_WAIT : S_REQ;
      drop_n     = outstanding;
      skid_vld_n = 1'b0;
      buf_vld_n  = 1'b0;
      fetch_pc_n = i_riscv_fetch_redirect_pc & ~64'd1;
      valid_n    = 1'b0;
      inst_n     = 32'h0;
    end else begin
      if (!i_riscv_fetch_stall) begin
        valid_n = 1'b0;
        inst_n  = 32'h0;
      end
      unique case (state)
        S_REQ: begin
          if (!i_riscv_fetch_stall) begin
            req_c   = 1'b1;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (drop) begin
            if (i_riscv_fetch_imem_rvalid) begin
              drop_n  = 1'b0;
              state_n = S_REQ;
            end
          end else if (wv && i_riscv_fetch_stall) begin
            skid_vld_n  = 1'b1;
            skid_data_n = wd;
          end else if (wv) begin
            skid_vld_n = 1'b0;
            if (!fetch_pc[1]) begin
              present = 1'b1;
              take_hi = det_rvc;
            end else begin
              present = det_rvc;
              take_hi = !det_rvc;
            end
            if (!take_hi) begin
              fetch_pc_n = word_a4;
              state_n    = S_REQ;
            end
          end
        end
        S_STRADDLE: begin
          if (wv && i_riscv_fetch_stall) begin
            skid_vld_n  = 1'b1;
            skid_data_n = wd;
          end else if (wv) begin
            skid_vld_n = 1'b0;
            present    = buf_vld;
            take_hi    = 1'b1;
          end
        end
        S_DRAIN: begin
          if (!i_riscv_fetch_stall && buf_vld) begin
            present    = 1'b1;
            buf_vld_n  = 1'b0;
            fetch_pc_n = det_next;
            state_n    = S_REQ;
          end
        end
      endcase

      if (present) begin
        valid_n = 1'b1;
        inst_n  = pres_inst;
        pc_n    = pres_pc;
        pc4_n   = det_next;
      end
      // Upper half stays behind: drain it, or fetch its other half.
      if (take_hi) begin
        buf_half_n = hi;
        buf_pc_n   = hi_pc;
        buf_vld_n  = 1'b1;
        if (hi_rvc) begin
          state_n = S_DRAIN;
        end else begin
          req_c      = 1'b1;
          addr_c     = word_a4;
          fetch_pc_n = word_a4;
          state_n    = S_STRADDLE;
        end
      end
    end
  end

  always_ff @(posedge i_riscv_fetch_clk) begin
    if (i_riscv_fetch_rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC & ~64'd1;
      buf_half  <= 16'h0;
      buf_pc    <= '0;
      buf_vld   <= 1'b0;
      drop      <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= 32'h0;
      valid_q   <= 1'b0;
      inst_q    <= 32'h0;
      pc_q      <= '0;
      pc4_q     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      buf_half  <= buf_half_n;
      buf_pc    <= buf_pc_n;
      buf_vld   <= buf_vld_n;
      drop      <= drop_n;
      skid_vld  <= skid_vld_n;
      skid_data <= skid_data_n;
      valid_q   <= valid_n;
      inst_q    <= inst_n;
      pc_q      <= pc_n;
      pc4_q     <= pc4_n;
    end
  end

  assign o_riscv_fetch_imem_req  = req_c && !i_riscv_fetch_rst;
  assign o_riscv_fetch_imem_addr = addr_c;
  assign o_riscv_fetch_pc_f      = pc_q;
  assign o_riscv_fetch_inst_f    = inst_q;
  assign o_riscv_fetch_pcplus4_f = pc4_q;
  assign o_riscv_fetch_valid_f   = valid_q;

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Directed bench for riscv_fetch_align: vector table
// plus reset, drain, stall and redirect sequences.
module tb_riscv_fetch_align;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] pc4;
  } ins_t;

  typedef struct packed {
    logic [63:0] start;
    int          lat;
    int          i0;
    logic [31:0] w0;
    int          i1;
    logic [31:0] w1;
    int          n;
    ins_t [0:2]  e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        req;
  logic [63:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [63:0] pc_f;
  logic [31:0] inst_f;
  logic [63:0] pc4_f;
  logic        valid_f;

  logic [31:0] mem [256];
  int          lat;
  bit          pend;
  int          cnt;
  logic [63:0] paddr;
  int          req_cnt;
  int          ovl;
  int          inv_err;
  logic [63:0] req_log [$];
  ins_t        q [$];
  int          nvec;
  int          nerr;
  vec_t        vt [8];

  riscv_fetch_align dut (
    .i_riscv_fetch_clk         (clk),
    .i_riscv_fetch_rst         (rst),
    .i_riscv_fetch_stall       (stall),
    .i_riscv_fetch_redirect    (redirect),
    .i_riscv_fetch_redirect_pc (redirect_pc),
    .o_riscv_fetch_imem_req    (req),
    .o_riscv_fetch_imem_addr   (addr),
    .i_riscv_fetch_imem_rvalid (rvalid),
    .i_riscv_fetch_imem_rdata  (rdata),
    .o_riscv_fetch_pc_f        (pc_f),
    .o_riscv_fetch_inst_f      (inst_f),
    .o_riscv_fetch_pcplus4_f   (pc4_f),
    .o_riscv_fetch_valid_f     (valid_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: one read in flight, answers lat cycles later.
  initial begin
    rvalid = 1'b0;
    rdata  = 32'h0;
    pend   = 1'b0;
    cnt    = 0;
    paddr  = '0;
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = 32'h0;
      if (pend) begin
        if (cnt <= 1) begin
          rvalid = 1'b1;
          rdata  = mem[paddr[9:2]];
          pend   = 1'b0;
        end else begin
          cnt--;
        end
      end
      #1;
      if (rst) begin
        pend = 1'b0;
      end else if (req) begin
        if (pend || addr[1:0] != 2'b00) ovl++;
        pend  = 1'b1;
        cnt   = lat;
        paddr = addr;
        req_cnt++;
        req_log.push_back(addr);
      end
    end
  end

  // Decode side: takes an instruction when valid and not stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !valid_f && inst_f !== 32'h0) inv_err++;
      if (valid_f && !stall && !redirect && !rst)
        q.push_back(ins_t'{pc_f, inst_f, pc4_f});
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_q(input int n, input string nm);
    int c = 0;
    while (q.size() < n && c < 200) begin
      @(posedge clk);
      c++;
    end
    nvec++;
    if (q.size() < n) begin
      nerr++;
      $display("FAIL %s timeout: got %0d instrs, want %0d",
               nm, q.size(), n);
    end
  endtask

  task automatic wait_req(input int n, input string nm);
    int c = 0;
    while (req_cnt < n && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    nvec++;
    if (req_cnt < n) begin
      nerr++;
      $display("FAIL %s timeout: got %0d reqs, want %0d",
               nm, req_cnt, n);
    end
  endtask

  task automatic chk_ins(input string nm, input int k,
                         input ins_t e);
    ins_t a;
    a = (k < q.size()) ? q[k] : '1;
    chk({nm, ".pc"}, a.pc, e.pc);
    chk({nm, ".inst"}, {32'h0, a.inst}, {32'h0, e.inst});
    chk({nm, ".pc4"}, a.pc4, e.pc4);
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) mem[a] = 32'h00000013;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    q.delete();
    req_log.delete();
    req_cnt = 0;
  endtask

  logic [63:0] s_pc, s_pc4;
  logic [31:0] s_inst;
  logic        s_v;
  bit          rv_seen;
  logic [63:0] la;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; lat = 1;
    req_cnt = 0; ovl = 0; inv_err = 0; nvec = 0; nerr = 0;

    vt[0] = '{64'h0, 1, 0, 32'h00500093, 1, 32'h00A00113, 2,
              '{'{64'h0, 32'h00500093, 64'h4},
                '{64'h4, 32'h00A00113, 64'h8}, '0}};
    vt[1] = '{64'h0, 1, 0, 32'h45054501, 1, 32'h00500093, 3,
              '{'{64'h0, 32'h00004501, 64'h2},
                '{64'h2, 32'h00004505, 64'h4},
                '{64'h4, 32'h00500093, 64'h8}}};
    vt[2] = '{64'h0, 2, 0, 32'h00934501, 1, 32'h45010050, 3,
              '{'{64'h0, 32'h00004501, 64'h2},
                '{64'h2, 32'h00500093, 64'h6},
                '{64'h6, 32'h00004501, 64'h8}}};
    vt[3] = '{64'h2, 1, 0, 32'h45051234, 1, 32'h00500093, 2,
              '{'{64'h2, 32'h00004505, 64'h4},
                '{64'h4, 32'h00500093, 64'h8}, '0}};
    vt[4] = '{64'h2, 3, 0, 32'h00931234, 1, 32'h00A00050, 2,
              '{'{64'h2, 32'h00500093, 64'h6},
                '{64'h6, 32'h000000A0, 64'h8}, '0}};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFE, 1, 255, 32'h45050000,
              0, 32'h00500093, 2,
              '{'{64'hFFFF_FFFF_FFFF_FFFE, 32'h00004505, 64'h0},
                '{64'h0, 32'h00500093, 64'h4}, '0}};
    vt[6] = '{64'hFFFF_FFFF_FFFF_FFFE, 2, 255, 32'h00930000,
              0, 32'h45010050, 2,
              '{'{64'hFFFF_FFFF_FFFF_FFFE, 32'h00500093, 64'h2},
                '{64'h2, 32'h00004501, 64'h4}, '0}};
    vt[7] = '{64'h5, 1, 1, 32'h00A00113, 2, 32'h00000013, 2,
              '{'{64'h4, 32'h00A00113, 64'h8},
                '{64'h8, 32'h00000013, 64'hC}, '0}};

    // Reset values, first request, two 32-bit words.
    fill_mem();
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    lat = 1;
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {63'h0, req}, 64'h0);
    chk("rst.valid", {63'h0, valid_f}, 64'h0);
    chk("rst.pc", pc_f, 64'h0);
    chk("rst.inst", {32'h0, inst_f}, 64'h0);
    chk("rst.pc4", pc4_f, 64'h0);
    rst = 1'b0;
    q.delete();
    req_log.delete();
    req_cnt = 0;
    @(negedge clk);
    chk("rst.first_req", {63'h0, req}, 64'h1);
    chk("rst.first_addr", addr, 64'h0);
    wait_q(2, "rst.seq");
    chk_ins("rst.i0", 0, '{64'h0, 32'h00500093, 64'h4});
    chk_ins("rst.i1", 1, '{64'h4, 32'h00A00113, 64'h8});

    // Table vectors, each entered through a redirect.
    for (int v = 0; v < 8; v++) begin
      fill_mem();
      mem[vt[v].i0] = vt[v].w0;
      mem[vt[v].i1] = vt[v].w1;
      lat = vt[v].lat;
      do_reset();
      @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = vt[v].start;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      q.delete();
      wait_q(vt[v].n, $sformatf("v%0d", v));
      for (int k = 0; k < vt[v].n; k++)
        chk_ins($sformatf("v%0d.e%0d", v, k), k, vt[v].e[k]);
    end

    // Two RVC in one word: second comes from the buffer.
    fill_mem();
    mem[0] = 32'h45054501;
    lat = 1;
    do_reset();
    wait_q(2, "drain");
    repeat (4) @(posedge clk);
    chk_ins("drain.i0", 0, '{64'h0, 32'h00004501, 64'h2});
    chk_ins("drain.i1", 1, '{64'h2, 32'h00004505, 64'h4});
    la = (req_log.size() > 0) ? req_log[0] : '1;
    chk("drain.req0", la, 64'h0);
    la = (req_log.size() > 1) ? req_log[1] : '1;
    chk("drain.req1", la, 64'h4);

    // Stall over a returning read: held outputs, data kept.
    fill_mem();
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    lat = 2;
    do_reset();
    wait_req(2, "stall.req");
    stall   = 1'b1;
    s_pc    = pc_f;
    s_pc4   = pc4_f;
    s_inst  = inst_f;
    s_v     = valid_f;
    rv_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      if (rvalid) rv_seen = 1'b1;
      chk("stall.pc", pc_f, s_pc);
      chk("stall.pc4", pc4_f, s_pc4);
      chk("stall.inst", {32'h0, inst_f}, {32'h0, s_inst});
      chk("stall.valid", {63'h0, valid_f}, {63'h0, s_v});
      chk("stall.req", {63'h0, req}, 64'h0);
    end
    chk("stall.rvalid_seen", {63'h0, rv_seen}, 64'h1);
    @(posedge clk);
    #1;
    stall = 1'b0;
    wait_q(2, "stall.seq");
    chk_ins("stall.i0", 0, '{64'h0, 32'h00500093, 64'h4});
    chk_ins("stall.i1", 1, '{64'h4, 32'h00A00113, 64'h8});

    // Redirect with a read in flight: stale word dropped.
    fill_mem();
    mem[0]  = 32'h00500093;
    mem[64] = 32'h45050000;
    lat = 4;
    do_reset();
    wait_req(1, "redir.req");
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    q.delete();
    req_log.delete();
    wait_q(1, "redir.seq");
    chk_ins("redir.i0", 0, '{64'h102, 32'h00004505, 64'h104});
    la = (req_log.size() > 0) ? req_log[0] : '1;
    chk("redir.req_addr", la, 64'h100);

    chk("proto.one_outstanding", 64'(ovl), 64'h0);
    chk("inst_zero_when_invalid", 64'(inv_err), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/riscv_fetch_align.md
RISCV_FETCH_ALIGN -- requirements
Module: riscv_fetch_align

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 i_riscv_fetch_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_riscv_fetch_rst  in  1  reset, synchronous, active-high.
REQ-004 i_riscv_fetch_stall  in  1  decode stage holding (same sense as the F/D register enable); outputs frozen.
REQ-005 i_riscv_fetch_redirect  in  1  taken branch/jump/trap; restart fetch at i_riscv_fetch_redirect_pc.
REQ-006 i_riscv_fetch_redirect_pc  in  64  redirect target, halfword-aligned (bit 0 ignored).
REQ-007 o_riscv_fetch_imem_req  out  1  instruction-memory read request, one outstanding maximum.
REQ-008 o_riscv_fetch_imem_addr  out  64  word-aligned read address (bits [1:0] = 0).
REQ-009 i_riscv_fetch_imem_rvalid  in  1  read data valid, arrives 1 or more cycles after req.
REQ-010 i_riscv_fetch_imem_rdata  in  32  read data word.
REQ-011 o_riscv_fetch_pc_f  out  64  PC of the presented instruction.
REQ-012 o_riscv_fetch_inst_f  out  32  instruction; RVC presented as {16'b0, half}.
REQ-013 o_riscv_fetch_pcplus4_f  out  64  sequential next PC: pc+2 (RVC) or pc+4.
REQ-014 o_riscv_fetch_valid_f  out  1  instruction outputs valid; when 0, inst_f SHALL be 32'h0.

Function
REQ-015 Halfword is RVC when bits [1:0] != 2'b11; otherwise it is the low half of a 32-bit instruction.
REQ-016 Block SHALL hold a 16-bit halfword buffer with valid bit and PC, plus a fetch PC register.
REQ-017 FSM states: REQ (issue read), WAIT (read outstanding), DRAIN (buffer holds a complete RVC, no read needed), STRADDLE (buffer holds low half of a 32-bit instruction, next word requested).
REQ-018 Word returned with fetch PC[1]=0: RVC low half -> present it, buffer high half (PC+2), go DRAIN if buffered half is RVC, else STRADDLE; 32-bit -> present full word, go REQ at PC+4.
REQ-019 Word returned with fetch PC[1]=1: high half RVC -> present it, go REQ at next word; otherwise buffer it, go STRADDLE.
REQ-020 STRADDLE return: present {rdata[15:0], buffer}, PC = buffer PC; then treat rdata[31:16] per REQ-018 buffering rule.
REQ-021 Output registers update only when i_riscv_fetch_stall=0; while stalled all o_*_f SHALL hold, no new request issued, returning rdata captured into a one-word skid register.
REQ-022 Latency: instruction appears on o_*_f the cycle after rvalid (registered); DRAIN presents one instruction per cycle with no memory access.
REQ-023 Redirect has priority over stall and all states: next cycle valid_f=0, buffer invalidated, fetch PC = redirect_pc, request at redirect_pc & ~3.
REQ-024 A read outstanding at redirect SHALL be discarded on return (drop flag), with the new request issued only after it returns.
REQ-025 PC arithmetic is 64-bit modulo 2^64; pc 64'hFFFF_FFFF_FFFF_FFFE + 2 wraps to 0.

Reset
REQ-026 During reset: imem_req=0, valid_f=0, pc_f=0, inst_f=0, pcplus4_f=0, buffer invalid, drop flag clear, skid empty.
REQ-027 First request after reset deassertion SHALL be at RESET_PC & ~3 in the following cycle; reset mid-read discards that read.

Structure
REQ-028 Shared package riscv_pkg SHALL hold the FSM state enum, RVC_OPMASK constant 2'b11 and XLEN=64.
REQ-029 One sub-module riscv_fetch_rvc_det (combinational RVC detect + pc increment select) is natural; everything else in one always_ff with a separate next-state block.

Verification
REQ-030 Reset, RESET_PC=0, words 32'h00500093, 32'h00A00113 -> pc_f 0 then 4, pcplus4_f 4 then 8, valid_f=1.
REQ-031 Word 32'h4505_4501 (two RVC) -> pc_f 0 inst 32'h4501, pc_f 2 inst 32'h4505 from DRAIN with no second read.
REQ-032 Word 32'h0093_4501 then 32'hXXXX_0050 -> RVC at 0, then inst 32'h00500093 at pc 2, pcplus4_f 6.
REQ-033 Stall held 3 cycles during rvalid -> o_*_f unchanged, no req, captured word presented after release without loss.
REQ-034 Redirect to 64'h102 with read outstanding -> stale data dropped, next req addr 64'h100, first valid pc_f 64'h102.
